regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Shares the single-port register file between `NUM_REQ` requesters, such as the UART command port and on-chip sequencers. Requester 0 is conventionally the UART. The arbiter chooses one pending request by round-robin and drives a one-cycle regfile write or read strobe. For reads, it returns the captured data to the winning requester. It sits between the requesters and the regfile, replacing their direct connection to the regfile's `write`/`read` strobes.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal values are 2 to 4.
- `AW`, default 8: regfile address width.
- `DW`, default 8: regfile data width.

- `clk`  input  1  controlling clock.
- `reset_n`  input  1  reset; asynchronous, active-low.
- `req`  input  `NUM_REQ`  per-requester access request, level.
- `req_we`  input  `NUM_REQ`  1 = write, 0 = read; valid while `req` is high.
- `req_addr`  input  `NUM_REQ*AW`  packed addresses; requester i uses bits `[i*AW +: AW]`.
- `req_wdata`  input  `NUM_REQ*DW`  packed write data, same packing as `req_addr`.
- `gnt`  output  `NUM_REQ`  one-hot, one-cycle grant pulse.
- `rvalid`  output  `NUM_REQ`  one-hot, one-cycle read-data-valid pulse.
- `rdata`  output  `DW`  read data, broadcast to all requesters; qualified by `rvalid`.
- `busy`  output  1  high whenever the state is not IDLE.
- `write`  output  1  regfile write strobe.
- `write_addr`  output  `AW`  regfile write address.
- `write_data`  output  `DW`  regfile write data.
- `read`  output  1  regfile read strobe.
- `read_addr`  output  `AW`  regfile read address.
- `read_data`  input  `DW`  regfile read data; must be valid by the end of the cycle in which `read` is high.

## Operation
- The state machine has three states: IDLE (0), GRANT (1), RDATA (2). Any unused encoding goes to IDLE on the next clock.
- **IDLE:** if `req` is nonzero at the clock edge:
  - Select the winner by round-robin. The search starts at `last+1` and wraps modulo `NUM_REQ`.
  - Latch the winner's index, `req_we`, `req_addr` and `req_wdata` into internal registers.
  - Set `last` to the winner.
  - Go to GRANT.
  - If `req` is zero, stay in IDLE.
- **GRANT** (exactly one cycle):
  - `gnt[winner]` = 1.
  - For a write: `write` = 1 with the latched address and data; next state is IDLE.
  - For a read: `read` = 1, `read_addr` = latched address; next state is RDATA.
  - `read_data` is captured into `rdata` on the edge that ends GRANT.
- **RDATA** (exactly one cycle): `rvalid[winner]` = 1 and `rdata` holds the captured data; next state is IDLE.
- All outputs are registered; none are driven combinationally from `req`.
- `req` is sampled only in IDLE. Requests raised during GRANT or RDATA wait; they are not lost, provided the requester holds them.
- Requester rules:
  - Hold `req`, `req_we`, `req_addr` and `req_wdata` stable until `gnt` is seen.
  - Drop `req` in the cycle after `gnt`. A `req` still high at the next IDLE sample is a new request.
- Round-robin:
  - `last` resets to `NUM_REQ-1`, so requester 0 wins the first contention after reset.
  - With all requesters pending continuously, grants rotate 0, 1, …, `NUM_REQ-1`, 0, …
- No requester waits more than `NUM_REQ-1` other accesses.
- `write_addr`, `write_data`, `read_addr` and `rdata` hold their last values between accesses.
- `write` and `read` are never high in the same cycle.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `busy`=0, `write`=0, `write_addr`=0, `write_data`=0, `read`=0, `read_addr`=0, state=IDLE, `last`=`NUM_REQ-1`.
- Asserting `reset_n` forces all of the above immediately, even mid-access. A pending read is discarded with no `rvalid`. A write strobe in flight is cut short.
- Write latency:
  - `req` sampled at edge k.
  - `gnt` and `write` are high in cycle k+1.
  - The regfile commits at edge k+2.
- Read latency: `req` sampled at edge k; `gnt` and `read` are high in cycle k+1; `rvalid`/`rdata` are valid in cycle k+2.
- Throughput: one write per 2 cycles, one read per 3 cycles (including the IDLE sample cycle).
- `busy` is high in exactly the GRANT and RDATA cycles.
- Simultaneous events:
  - A request arriving on the same edge as a different requester's grant is queued for the next IDLE.
  - If the winner's `req` drops during GRANT, the access still completes.

## Test plan
- **Reset:** assert `reset_n`=0 during a read's GRANT cycle → all outputs 0 immediately, no `rvalid`. After release, `req`=2'b01 selects requester 0.
- **Single write:** requester 0 issues `we`=1, addr=8'h12, data=8'hA5 → `gnt[0]` and `write` high one cycle after sampling, with `write_addr`=8'h12 and `write_data`=8'hA5; `busy` high for one cycle.
- **Single read:** requester 1 reads addr=8'h30 while the regfile model returns 8'h5C → `read` high with `read_addr`=8'h30, then `rvalid`=2'b10 and `rdata`=8'h5C on the following cycle.
- **Contention:** `req`=2'b11 held after each grant, four accesses → grant order 0, 1, 0, 1, with no `write` and `read` overlap.
- **`NUM_REQ`=4:** all four requesting after `last`=2 → grant order 3, 0, 1, 2.
- **Late request:** requester 1 raises `req` during requester 0's RDATA cycle → requester 1 is granted 2 cycles after RDATA ends, with its own latched addr/data and no corruption of requester 0's `rdata`.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a single-port register file between NUM_REQ requesters.
// Each access is a registered one-cycle write or read strobe; reads return data one cycle later.
module regfile_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  write,
    output logic [AW-1:0]         write_addr,
    output logic [DW-1:0]         write_data,
    output logic                  read,
    output logic [AW-1:0]         read_addr,
    input  logic [DW-1:0]         read_data
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StRdata = 2'd2
    } state_e;

    state_e              state_q;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       win_idx_q;
    logic                win_we_q;
    logic [IW-1:0]       winner;
    logic [IW-1:0]       cand;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [NUM_REQ-1:0]  held_onehot;
    logic [AW-1:0]       addr_arr  [NUM_REQ];
    logic [DW-1:0]       wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*AW +: AW];
        assign wdata_arr[i] = req_wdata[i*DW +: DW];
    end

    // Scan from the farthest offset down so the nearest pending requester after last_q wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            cand = IW'((32'(last_q) + off) % NUM_REQ);
            if (req[cand]) winner = cand;
        end
    end

    always_comb begin
        win_onehot  = '0;
        held_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            win_onehot[i]  = (winner == IW'(i));
            held_onehot[i] = (win_idx_q == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            last_q     <= IW'(NUM_REQ - 1);
            win_idx_q  <= '0;
            win_we_q   <= 1'b0;
            gnt        <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            write      <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            read       <= 1'b0;
            read_addr  <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            write  <= 1'b0;
            read   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        last_q    <= winner;
                        win_idx_q <= winner;
                        win_we_q  <= req_we[winner];
                        gnt       <= win_onehot;
                        busy      <= 1'b1;
                        state_q   <= StGrant;
                        if (req_we[winner]) begin
                            write      <= 1'b1;
                            write_addr <= addr_arr[winner];
                            write_data <= wdata_arr[winner];
                        end else begin
                            read      <= 1'b1;
                            read_addr <= addr_arr[winner];
                        end
                    end
                end
                StGrant: begin
                    if (win_we_q) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        // Regfile data is valid by the end of the read strobe cycle.
                        rdata   <= read_data;
                        rvalid  <= held_onehot;
                        state_q <= StRdata;
                    end
                end
                StRdata: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a 2-requester instance plus a 4-requester instance
// for rotation order.
module tb_regfile_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata, write_addr, write_data, read_addr, rf_rdata;
    logic        busy, write, read;

    logic [3:0]  req4, req_we4, gnt4, rvalid4;
    logic [31:0] req_addr4, req_wdata4;
    logic [7:0]  rdata4, write_addr4, write_data4, read_addr4, rf_rdata4;
    logic        busy4, write4, read4;

    int tests_run;
    int tests_failed;

    regfile_arbiter #(.NUM_REQ(2), .AW(8), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .write(write), .write_addr(write_addr), .write_data(write_data), .read(read),
        .read_addr(read_addr), .read_data(rf_rdata)
    );

    regfile_arbiter #(.NUM_REQ(4), .AW(8), .DW(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req4), .req_we(req_we4), .req_addr(req_addr4),
        .req_wdata(req_wdata4), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .busy(busy4),
        .write(write4), .write_addr(write_addr4), .write_data(write_data4), .read(read4),
        .read_addr(read_addr4), .read_data(rf_rdata4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({gnt, rvalid, busy, write, read} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 0", {gnt, rvalid, busy, write, read});
        end
        tests_run++;
        if ({rdata, write_addr, write_data, read_addr} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0", {rdata, write_addr, write_data, read_addr});
        end
        reset_n = 1'b1;
        // Start a read and reset in its GRANT cycle.
        req = 2'b01; req_we = 2'b00; req_addr = 16'h0044; rf_rdata = 8'h77;
        tick();
        tests_run++;
        if (gnt !== 2'b01 || read !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_grant: got gnt=%b read=%b want 01/1", gnt, read);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({gnt, busy, read, write} !== 5'b0 || read_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_async: got gnt=%b busy=%b read=%b addr=%h want 0",
                     gnt, busy, read, read_addr);
        end
        req = 2'b00;
        tick();
        tests_run++;
        if (rvalid !== 2'b00 || rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_no_rvalid: got rvalid=%b rdata=%h want 00/00", rvalid, rdata);
        end
        reset_n = 1'b1;
        req = 2'b01; req_we = 2'b01; req_addr = 16'h0001; req_wdata = 16'h0002;
        tick();
        tests_run++;
        if (gnt !== 2'b01 || write !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got gnt=%b write=%b want 01/1", gnt, write);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_single_write();
        req = 2'b01; req_we = 2'b01; req_addr = 16'h0012; req_wdata = 16'h00A5;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_idle_busy: got %b want 0", busy);
        end
        tick();
        tests_run++;
        if (gnt !== 2'b01 || write !== 1'b1 || read !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_strobe: got gnt=%b write=%b read=%b busy=%b want 01/1/0/1",
                     gnt, write, read, busy);
        end
        tests_run++;
        if (write_addr !== 8'h12 || write_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL write_payload: got %h/%h want 12/a5", write_addr, write_data);
        end
        req = 2'b00;
        tick();
        tests_run++;
        if (gnt !== 2'b00 || write !== 1'b0 || busy !== 1'b0 || write_addr !== 8'h12) begin
            tests_failed++;
            $display("FAIL write_done: got gnt=%b write=%b busy=%b addr=%h want 00/0/0/12",
                     gnt, write, busy, write_addr);
        end
        tick();
    endtask

    task automatic test_single_read();
        req = 2'b10; req_we = 2'b00; req_addr = 16'h3000; rf_rdata = 8'h5C;
        tick();
        tests_run++;
        if (gnt !== 2'b10 || read !== 1'b1 || write !== 1'b0 || read_addr !== 8'h30) begin
            tests_failed++;
            $display("FAIL read_strobe: got gnt=%b read=%b write=%b addr=%h want 10/1/0/30",
                     gnt, read, write, read_addr);
        end
        req = 2'b00;
        tick();
        tests_run++;
        if (rvalid !== 2'b10 || rdata !== 8'h5C || read !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_data: got rvalid=%b rdata=%h read=%b busy=%b want 10/5c/0/1",
                     rvalid, rdata, read, busy);
        end
        rf_rdata = 8'hEE;
        tick();
        tests_run++;
        if (rvalid !== 2'b00 || busy !== 1'b0 || rdata !== 8'h5C) begin
            tests_failed++;
            $display("FAIL read_after: got rvalid=%b busy=%b rdata=%h want 00/0/5c",
                     rvalid, busy, rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic [7:0] exp_addr;
        req = 2'b11; req_we = 2'b11; req_addr = 16'hB1A0; req_wdata = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (i % 2 == 0) ? 8'hA0 : 8'hB1;
            tick();
            tests_run++;
            if (gnt !== exp_gnt || write_addr !== exp_addr || (write && read)) begin
                tests_failed++;
                $display("FAIL contention_%0d: got gnt=%b addr=%h wr=%b rd=%b want %b/%h",
                         i, gnt, write_addr, write, read, exp_gnt, exp_addr);
            end
            tick();
        end
        req = 2'b00;
        tick();
        tests_run++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL contention_idle: got busy=%b gnt=%b want 0/00", busy, gnt);
        end
    endtask

    task automatic test_num_req4();
        logic [3:0] exp_gnt;
        req4 = 4'b0100; req_we4 = 4'b1111;
        tick();
        tests_run++;
        if (gnt4 !== 4'b0100) begin
            tests_failed++;
            $display("FAIL nr4_setup: got %b want 0100", gnt4);
        end
        req4 = 4'b0000;
        tick();
        req4 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = 4'b0001 << ((3 + i) % 4);
            tick();
            tests_run++;
            if (gnt4 !== exp_gnt || write4 !== 1'b1) begin
                tests_failed++;
                $display("FAIL nr4_order_%0d: got gnt=%b write=%b want %b/1",
                         i, gnt4, write4, exp_gnt);
            end
            tick();
        end
        req4 = 4'b0000;
        tick();
    endtask

    task automatic test_late_request();
        req = 2'b01; req_we = 2'b00; req_addr = 16'h0055; rf_rdata = 8'h3C;
        tick();
        tests_run++;
        if (gnt !== 2'b01 || read_addr !== 8'h55) begin
            tests_failed++;
            $display("FAIL late_grant0: got gnt=%b addr=%h want 01/55", gnt, read_addr);
        end
        req = 2'b00;
        tick();
        tests_run++;
        if (rvalid !== 2'b01 || rdata !== 8'h3C) begin
            tests_failed++;
            $display("FAIL late_rdata0: got rvalid=%b rdata=%h want 01/3c", rvalid, rdata);
        end
        // Requester 1 arrives during RDATA; the regfile bus now shows unrelated data.
        req = 2'b10; req_we = 2'b10; req_addr = 16'h6600; req_wdata = 16'h9900; rf_rdata = 8'hFF;
        tick();
        tests_run++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || busy !== 1'b0 || rdata !== 8'h3C) begin
            tests_failed++;
            $display("FAIL late_idle: got gnt=%b rvalid=%b busy=%b rdata=%h want 00/00/0/3c",
                     gnt, rvalid, busy, rdata);
        end
        tick();
        tests_run++;
        if (gnt !== 2'b10 || write !== 1'b1 || write_addr !== 8'h66 || write_data !== 8'h99) begin
            tests_failed++;
            $display("FAIL late_grant1: got gnt=%b write=%b addr=%h data=%h want 10/1/66/99",
                     gnt, write, write_addr, write_data);
        end
        tests_run++;
        if (rdata !== 8'h3C) begin
            tests_failed++;
            $display("FAIL late_rdata_hold: got %h want 3c", rdata);
        end
        req = 2'b00;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        req          = '0; req_we = '0; req_addr = '0; req_wdata = '0; rf_rdata = '0;
        req4         = '0; req_we4 = '0; req_addr4 = 32'h3322_1100;
        req_wdata4   = 32'h4433_2211; rf_rdata4 = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_num_req4();
        test_late_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
